// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps one of four 8-bit patterns at a programmable rate,
// with rate/mode reconfiguration accepted over a valid/ready handshake.
module led_pattern_sequencer #(
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_mode,
  output logic [7:0]           LED,
  output logic                 dir,
  output logic                 step_tick
);

  typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_t;

  localparam logic [1:0] MODE_BOUNCE     = 2'd0;
  localparam logic [1:0] MODE_RING_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RING_RIGHT = 2'd2;
  localparam logic [1:0] MODE_BLINK      = 2'd3;

  state_t               state_q;
  logic [7:0]           led_q, led_d;
  logic                 dir_q, dir_d;
  logic                 tick_q;
  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           mode_q;

  logic [DIV_WIDTH-1:0] divEff;
  logic                 lastCount;
  logic                 xfer;
  logic                 ledOneHot;

  assign cfg_ready = !reset && (state_q != RELOAD);
  assign xfer      = cfg_valid && cfg_ready;
  assign divEff    = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign lastCount = (count_q == divEff - DIV_WIDTH'(1));
  assign ledOneHot = (led_q != 8'h00) && ((led_q & (led_q - 8'h01)) == 8'h00);

  assign LED       = led_q;
  assign dir       = dir_q;
  assign step_tick = tick_q;

  // Pattern successor for the current mode; only BOUNCE touches the direction flag.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (!ledOneHot) begin
          led_d = 8'h01;
          dir_d = 1'b1;
        end else if (dir_q) begin
          if (led_q == 8'h80) begin
            led_d = 8'h40;
            dir_d = 1'b0;
          end else begin
            led_d = led_q << 1;
            dir_d = (led_q != 8'h40);
          end
        end else begin
          if (led_q == 8'h01) begin
            led_d = 8'h02;
            dir_d = 1'b1;
          end else begin
            led_d = led_q >> 1;
            dir_d = (led_q == 8'h02);
          end
        end
      end
      MODE_RING_LEFT:  led_d = {led_q[6:0], led_q[7]};
      MODE_RING_RIGHT: led_d = {led_q[0], led_q[7:1]};
      MODE_BLINK:      led_d = ~led_q;
      default:         led_d = led_q;
    endcase
  end

  // A pause freezes the count, but a tick that lands on the pause edge still steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      led_q   <= 8'h01;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      count_q <= '0;
      mode_q  <= MODE_BOUNCE;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            mode_q  <= cfg_mode;
            div_q   <= cfg_div;
            state_q <= RELOAD;
          end else if (run) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            mode_q  <= cfg_mode;
            div_q   <= cfg_div;
            state_q <= RELOAD;
          end else begin
            if (lastCount) begin
              count_q <= '0;
              led_q   <= led_d;
              dir_q   <= dir_d;
              tick_q  <= 1'b1;
            end else if (run) begin
              count_q <= count_q + DIV_WIDTH'(1);
            end
            if (!run) state_q <= IDLE;
          end
        end
        RELOAD: begin
          count_q <= '0;
          led_q   <= (mode_q == MODE_BLINK) ? 8'h00 : 8'h01;
          dir_q   <= 1'b1;
          state_q <= run ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Synchronous controller for the 8-bit LED pattern datapath, running on the system clock.
- Generates its own step enable from a programmable divider rather than clocking the pattern from a divided clock.
- Sequences one of four patterns; the default is the one-hot ping-pong bounce.
- Accepts rate/mode reconfiguration through a valid/ready handshake; run/pause comes from a top-level switch (synchronised upstream).

Parameters:
- DIV_WIDTH, 32: width of the divider count and of cfg_div.
- DEFAULT_DIV, 25000000: cycles per pattern step after reset (2 steps/s at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = advance pattern, 0 = pause and hold.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config can be accepted this cycle.
- cfg_div  in  DIV_WIDTH  cycles per step; 0 is treated as 1.
- cfg_mode  in  2  0 BOUNCE, 1 RING_LEFT, 2 RING_RIGHT, 3 BLINK.
- LED  out  8  pattern output, registered.
- dir  out  1  BOUNCE direction: 1 = moving toward bit 7, 0 = toward bit 0.
- step_tick  out  1  one-cycle pulse on each pattern step.

Behaviour:
- Reset, at the edge with reset=1 (has priority over everything):
  - LED=8'h01, dir=1, step_tick=0, cfg_ready=1, count=0.
  - mode=BOUNCE, div=DEFAULT_DIV, state=IDLE.
- div_eff = (div==0) ? 1 : div.
- States: IDLE, RUN, RELOAD.
- IDLE:
  - LED, dir and count hold.
  - run=1 -> RUN next edge.
  - Accepted config -> RELOAD.
- RUN:
  - count increments each cycle.
  - When count==div_eff-1: count<=0, LED<=next(LED), step_tick<=1 on that same edge. step_tick is otherwise 0.
  - First step occurs exactly div_eff cycles after entering RUN.
  - run=0 -> IDLE next edge; count freezes, so resuming completes the partial interval.
  - A tick coinciding with run=0 still steps.
- RELOAD (exactly 1 cycle):
  - cfg_ready=0.
  - count<=0; LED<=8'h01 and dir<=1, except BLINK loads LED<=8'h00.
  - Then RUN if run=1, else IDLE.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a clock edge; mode and div are latched on that edge.
  - cfg_ready=1 in IDLE and RUN, 0 in RELOAD and during reset.
  - A transfer in RUN takes priority over a coincident tick: the tick is discarded and no step_tick is issued.
  - A transfer with run=0 is still applied.
- next() for BOUNCE:
  - dir=1: shift left; on reaching 8'h80, dir<=0.
  - dir=0: shift right; on reaching 8'h01, dir<=1.
  - Period is 14 steps: 01,02,...,80,40,...,01.
  - LED not one-hot (unreachable) -> LED<=8'h01, dir<=1.
- next() for other modes:
  - RING_LEFT: rotate left, 8'h80 -> 8'h01.
  - RING_RIGHT: rotate right, 8'h01 -> 8'h80.
  - BLINK: LED <= ~LED (00/FF).
  - dir holds in all three.
- Widths: count is DIV_WIDTH bits; compare against div_eff-1 with no overflow (div_eff>=1).
- Reset mid-RUN or mid-RELOAD returns to the reset values on the next edge; any pending config is lost.

Test Plan:
- Reset held 3 cycles, then released with run=0 for 20 cycles -> LED=01, dir=1, cfg_ready=1, step_tick never asserted.
- cfg_div=2, mode=0 accepted; run=1 -> step_tick every 2 cycles; LED runs 02,04,...,80 (dir->0 on 80), 40,...,01 (dir->1); after 14 ticks LED=01.
- div=4, run=1; drop run for 10 cycles at count=2, then reassert -> LED holds; next step_tick exactly 2 cycles into RUN (count frozen at 2).
- cfg_div=0, mode=1, run=1 -> step_tick every cycle; LED 01,02,...,80,01; mode=2 reload -> LED 01, then 80,40,...
- mode=3, div=3, run=1 -> LED 00 after RELOAD, then FF,00,FF at 3-cycle spacing; cfg_ready low exactly the RELOAD cycle.
- Config offered on the tick cycle (div=2, LED=08) -> no step_tick; LED=01 after RELOAD. Separately, reset pulsed mid-RUN at LED=20 -> LED=01, mode=BOUNCE, div=DEFAULT_DIV, state IDLE.
